double_to_float: RTL and testbench

// - Streaming IEEE-754 binary64 -> binary32 narrowing stage, directly downstream of double_multiplier.
// - Consumes the multiplier's output_z stream and emits single-precision results to the next consumer (e.g. file_writer).
// - Rounding is round-to-nearest-even. Overflow saturates to infinity. NaN and signed zero are preserved.
// - Uses the codebase's stb/ack handshake on both sides.

---
 rtl/double_to_float.sv | 104 ++++++++++
 tb/tb_double_to_float.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/double_to_float.sv
// double_to_float: streaming binary64 -> binary32 narrowing stage (RNE, overflow to inf); define DENORMAL_OUT_EN for denormal outputs
module double_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  typedef enum logic [2:0] {GET_A, UNPACK, ROUND, PACK, PUT_Z} state_t;
  typedef enum logic [2:0] {C_NAN, C_INF, C_ZERO, C_OVF, C_NORM, C_TINY} cls_t;
  state_t state, state_n;
  cls_t cls, cls_u;
  logic [63:0] a;
  logic s;
  logic [51:0] m;
  logic [11:0] fe, fe_u, fe_n;
  logic [24:0] sum;
  logic [22:0] mant, mant_n;
  logic [23:0] dmant, dmant_n;
  logic [31:0] z, z_n;
  logic in_xfer, out_xfer;
  assign in_xfer = state == GET_A && input_a_ack && input_a_stb;
  assign out_xfer = state == PUT_Z && output_z_stb && output_z_ack;
  assign fe_u = {1'b0, a[62:52]} - 12'd896;
  assign sum = {2'b01, m[51:29]} + 25'(m[28] & (m[27] | (|m[26:0]) | m[29]));
  assign mant_n = sum[24] ? sum[23:1] : sum[22:0];
  assign fe_n = fe + 12'(sum[24]);
`ifdef DENORMAL_OUT_EN
  logic [11:0] shift;
  logic [52:0] sig, t;
  logic [23:0] dm;
  logic lost;
  assign shift = 12'd1 - fe;
  assign sig = {1'b1, m};
  assign t = sig >> shift[4:0];
  assign lost = |(sig & ~({53{1'b1}} << shift[4:0]));
  assign dm = t[52:29];
  assign dmant_n = shift >= 12'd26 ? 24'd0 : dm + 24'(t[28] & (t[27] | (|t[26:0]) | lost | dm[0]));
`else
  assign dmant_n = 24'd0;
`endif
  // classify the captured operand; denormal doubles are far below the float range
  always_comb
    cls_u = a[62:52] == 11'h7FF ? (|a[51:0] ? C_NAN : C_INF) :
            a[62:52] == 11'h0 ? C_ZERO :
            $signed(fe_u) >= 12'sd255 ? C_OVF :
            $signed(fe_u) >= 12'sd1 ? C_NORM : C_TINY;
  // assemble the binary32 word; a rounding carry to exponent 255 saturates
  always_comb
    z_n = cls == C_NAN ? {s, 8'hFF, 1'b1, m[50:29]} :
          (cls == C_INF || cls == C_OVF || (cls == C_NORM && fe == 12'd255)) ? {s, 8'hFF, 23'h0} :
          cls == C_ZERO ? {s, 31'h0} :
          cls == C_NORM ? {s, fe[7:0], mant} : {s, 7'h0, dmant};
  // next-state: fixed walk through the pipeline, waiting only on the two handshakes
  always_comb
    state_n = state == GET_A ? (in_xfer ? UNPACK : GET_A) :
              state == UNPACK ? ROUND :
              state == ROUND ? PACK :
              state == PACK ? PUT_Z : (out_xfer ? GET_A : PUT_Z);
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= GET_A;
    else state <= state_n;
  // handshake registers; ack re-opens on the output transfer edge so no cycle is lost
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      input_a_ack <= 1'b0;
      output_z_stb <= 1'b0;
      output_z <= 32'h0;
    end else begin
      input_a_ack <= state == GET_A ? !in_xfer : out_xfer;
      output_z_stb <= state == PUT_Z && !out_xfer;
      if (state == PUT_Z && !output_z_stb) output_z <= z;
    end
  // datapath registers, one stage per state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a <= 64'h0;
      s <= 1'b0;
      m <= 52'h0;
      fe <= 12'h0;
      cls <= C_ZERO;
      mant <= 23'h0;
      dmant <= 24'h0;
      z <= 32'h0;
    end else begin
      if (in_xfer) a <= input_a;
      if (state == UNPACK) begin
        s <= a[63];
        m <= a[51:0];
        fe <= fe_u;
        cls <= cls_u;
      end
      if (state == ROUND) begin
        mant <= mant_n;
        fe <= fe_n;
        dmant <= dmant_n;
      end
      if (state == PACK) z <= z_n;
    end
endmodule

// File: tb/tb_double_to_float.sv
// tb_double_to_float: randomized and directed checks of double_to_float against an arithmetic rounding model
module tb_double_to_float;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [63:0] input_a = 64'h0;
  logic input_a_stb = 1'b0;
  logic input_a_ack;
  logic [31:0] output_z;
  logic output_z_stb;
  logic output_z_ack = 1'b0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [63:0] in_q[$];
  int in_t[$];
  logic [31:0] out_q[$];
`ifdef DENORMAL_OUT_EN
  localparam logic [31:0] TINY1 = 32'h00000001;
`else
  localparam logic [31:0] TINY1 = 32'h00000000;
`endif

  double_to_float dut (
    .clk(clk),
    .rst(rst),
    .input_a(input_a),
    .input_a_stb(input_a_stb),
    .input_a_ack(input_a_ack),
    .output_z(output_z),
    .output_z_stb(output_z_stb),
    .output_z_ack(output_z_ack)
  );

  always #5 clk = ~clk;

  // log every transfer on both sides with the pre-edge values
  always @(posedge clk) begin
    cyc++;
    if (input_a_stb && input_a_ack) begin
      in_q.push_back(input_a);
      in_t.push_back(cyc);
    end
    if (output_z_stb && output_z_ack) out_q.push_back(output_z);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout req=finish");
    $fatal(1, "watchdog");
  end

  function automatic longint unsigned rne(input longint unsigned x, input int sh);
    longint unsigned q, rem, half;
    q = x >> sh;
    rem = x - (q << sh);
    half = 64'd1 << (sh - 1);
    return (rem > half || (rem == half && q[0])) ? q + 1 : q;
  endfunction

  // value = sig * 2^(ue-52); round it onto the float grid whose lsb weight is 2^(max(ue,-126)-23)
  function automatic logic [31:0] model(input logic [63:0] d);
    logic s;
    int e, ue, sh;
    longint unsigned sig, n;
    s = d[63];
    e = int'(d[62:52]);
    if (e == 2047) return d[51:0] != 0 ? {s, 8'hFF, 1'b1, d[50:29]} : {s, 8'hFF, 23'h0};
    if (e == 0) return {s, 31'h0};
    ue = e - 1023;
    sh = ((ue < -126) ? -126 : ue) - 23 - (ue - 52);
    sig = (64'd1 << 52) | longint'(d[51:0]);
    n = sh > 60 ? 64'd0 : rne(sig, sh);
    if (ue >= -126 && n == (64'd1 << 24)) begin
      n = 64'd1 << 23;
      ue++;
    end
    if (ue > 127) return {s, 8'hFF, 23'h0};
    if (ue >= -126) return {s, 8'(ue + 127), n[22:0]};
`ifdef DENORMAL_OUT_EN
    return {s, n[30:0]};
`else
    return {s, 31'h0};
`endif
  endfunction

  task automatic send(input logic [63:0] d);
    int n, k;
    n = in_q.size();
    k = 0;
    @(negedge clk);
    input_a = d;
    input_a_stb = 1'b1;
    while (in_q.size() == n && k < 40) begin
      @(negedge clk);
      k++;
    end
    input_a_stb = 1'b0;
    checks++;
    if (in_q.size() == n) begin
      errors++;
      $display("FAIL send_accept got=no_transfer req=transfer a=%h", d);
    end
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (out_q.size() < n && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (out_q.size() < n) begin
      errors++;
      $display("FAIL wait_out got=%0d results req=%0d", out_q.size(), n);
    end
  endtask

  task automatic test_reset;
    #3;
    checks += 3;
    if (input_a_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b req=0", input_a_ack); end
    if (output_z_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got=%b req=0", output_z_stb); end
    if (output_z !== 32'h0) begin errors++; $display("FAIL reset_z got=%h req=00000000", output_z); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (input_a_ack !== 1'b1) begin errors++; $display("FAIL reset_release_ack got=%b req=1", input_a_ack); end
  endtask

  task automatic test_latency;
    int n;
    output_z_ack = 1'b0;
    send(64'h3FF0000000000000);
    n = 0;
    while (output_z_stb !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks += 3;
    if (n != 4) begin errors++; $display("FAIL latency got=%0d edges req=4", n); end
    if (output_z !== 32'h3F800000) begin errors++; $display("FAIL latency_z got=%h req=3f800000", output_z); end
    if (input_a_ack !== 1'b0) begin errors++; $display("FAIL ack_overlap got=%b req=0", input_a_ack); end
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
  endtask

  task automatic test_directed;
    logic [63:0] va [10];
    logic [31:0] ve [10];
    logic [31:0] got;
    int base;
    va = '{64'h3FF0000000000000, 64'h3FF0000010000000, 64'h3FF0000030000000, 64'h47EFFFFFF0000000,
           64'h7FF0000000000000, 64'hFFF8000000000000, 64'h8000000000000000, 64'h36A0000000000000,
           64'h3810000000000000, 64'h0000000000000001};
    ve = '{32'h3F800000, 32'h3F800000, 32'h3F800002, 32'h7F800000,
           32'h7F800000, 32'hFFC00000, 32'h80000000, TINY1,
           32'h00800000, 32'h00000000};
    output_z_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      base = out_q.size();
      send(va[i]);
      wait_out(base + 1);
      got = out_q.size() > base ? out_q[base] : 32'hxxxxxxxx;
      checks++;
      if (got !== ve[i]) begin errors++; $display("FAIL directed_%0d a=%h got=%h req=%h", i, va[i], got, ve[i]); end
    end
  endtask

  task automatic test_random;
    logic [63:0] d;
    logic [51:0] m;
    logic [10:0] e;
    logic [31:0] got, exp;
    int r, base;
    output_z_ack = 1'b1;
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      m = {20'($urandom), 32'($urandom)};
      if (r == 2) m[28:0] = 29'h10000000;
      e = r == 0 ? 11'h0 : r == 1 ? 11'h7FF : 11'(856 + $urandom_range(0, 305));
      d = {1'($urandom), e, m};
      exp = model(d);
      base = out_q.size();
      send(d);
      wait_out(base + 1);
      got = out_q.size() > base ? out_q[base] : 32'hxxxxxxxx;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random_%0d a=%h got=%h req=%h", i, d, got, exp); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] ops [3];
    logic [31:0] z0, got;
    int bi, bo, k;
    for (int i = 0; i < 3; i++) ops[i] = {1'($urandom), 11'(1000 + $urandom_range(0, 100)), 20'($urandom), 32'($urandom)};
    bi = in_q.size();
    bo = out_q.size();
    output_z_ack = 1'b0;
    @(negedge clk);
    input_a = ops[0];
    input_a_stb = 1'b1;
    k = 0;
    while (in_q.size() == bi && k < 40) begin @(negedge clk); k++; end
    input_a = ops[1];
    k = 0;
    while (output_z_stb !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    z0 = output_z;
    checks++;
    if (z0 !== model(ops[0])) begin errors++; $display("FAIL bp_value got=%h req=%h", z0, model(ops[0])); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (output_z_stb !== 1'b1 || output_z !== z0 || input_a_ack !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got=stb%b z=%h ack%b req=stb1 z=%h ack0", i, output_z_stb, output_z, input_a_ack, z0);
      end
    end
    checks++;
    if (in_q.size() != bi + 1) begin errors++; $display("FAIL bp_early_accept got=%0d req=%0d", in_q.size() - bi, 1); end
    output_z_ack = 1'b1;
    k = 0;
    while (in_q.size() < bi + 2 && k < 40) begin @(negedge clk); k++; end
    input_a = ops[2];
    k = 0;
    while (in_q.size() < bi + 3 && k < 40) begin @(negedge clk); k++; end
    input_a_stb = 1'b0;
    wait_out(bo + 3);
    for (int i = 0; i < 3; i++) begin
      got = out_q.size() > bo + i ? out_q[bo + i] : 32'hxxxxxxxx;
      checks++;
      if (got !== model(ops[i])) begin errors++; $display("FAIL b2b_order_%0d got=%h req=%h", i, got, model(ops[i])); end
    end
    checks++;
    if (in_t.size() < bi + 3 || in_t[bi + 2] - in_t[bi + 1] != 6) begin
      errors++;
      $display("FAIL throughput got=%0d req=6", in_t.size() >= bi + 3 ? in_t[bi + 2] - in_t[bi + 1] : -1);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got;
    int bo;
    output_z_ack = 1'b1;
    bo = out_q.size();
    send(64'h4000000000000000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks += 3;
    if (input_a_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack got=%b req=0", input_a_ack); end
    if (output_z_stb !== 1'b0) begin errors++; $display("FAIL midrst_stb got=%b req=0", output_z_stb); end
    if (output_z !== 32'h0) begin errors++; $display("FAIL midrst_z got=%h req=00000000", output_z); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (input_a_ack !== 1'b1) begin errors++; $display("FAIL midrst_release_ack got=%b req=1", input_a_ack); end
    if (out_q.size() != bo) begin errors++; $display("FAIL midrst_discard got=%0d results req=0", out_q.size() - bo); end
    send(64'hC00C000000000000);
    wait_out(bo + 1);
    repeat (8) @(negedge clk);
    got = out_q.size() > bo ? out_q[bo] : 32'hxxxxxxxx;
    checks += 2;
    if (got !== 32'hC0600000) begin errors++; $display("FAIL midrst_next got=%h req=c0600000", got); end
    if (out_q.size() != bo + 1) begin errors++; $display("FAIL midrst_count got=%0d req=1", out_q.size() - bo); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
